// File: rtl/uart_frame_transmitter.sv
// uart_frame_transmitter: 20-bit parallel-to-serial UART (start=1, MSB-first data, stop=0, idle low).
// Define UART_TX_BUFFER_EN to add a one-entry holding register so a message can be queued mid-frame.
module uart_frame_transmitter #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MSG_WIDTH    = 20,
    parameter int IDLE_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [MSG_WIDTH-1:0] msgIn,
    input  logic                 send,
    output logic                 ready,
    output logic                 serialOut,
    output logic                 busy,
    output logic                 frameDone
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(MSG_WIDTH + 1);
    localparam int GW = $clog2(IDLE_BITS * CLKS_PER_BIT + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(MSG_WIDTH - 1);
    // The IDLE cycle in which the next accept happens is part of the line gap, so GAP is one cycle short.
    localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_BITS > 0) ? IDLE_BITS * CLKS_PER_BIT - 2 : 0);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_e;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [MSG_WIDTH-1:0]   shift_q, shift_d;
    logic                   serial_q, serial_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   accept;
`ifdef UART_TX_BUFFER_EN
    logic [MSG_WIDTH-1:0]   hold_q, hold_d;
    logic                   hold_valid_q, hold_valid_d;
`endif
    assign accept    = send && ready_q;
    assign ready     = ready_q;
    assign serialOut = serial_q;
    assign busy      = busy_q;
    assign frameDone = done_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        done_d  = 1'b0;
`ifdef UART_TX_BUFFER_EN
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shift_d = msgIn;
                    cnt_d   = '0;
                end
`ifdef UART_TX_BUFFER_EN
                else if (hold_valid_q) begin
                    state_d      = START;
                    shift_d      = hold_q;
                    cnt_d        = '0;
                    hold_valid_d = 1'b0;
                end
`endif
            end
            START: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    shift_d = {shift_q[MSG_WIDTH-2:0], 1'b0};
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == BIT_LAST) ? STOP : DATA;
                end
            end
            STOP: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = (IDLE_BITS == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                gap_d   = gap_q + 1'b1;
                state_d = (gap_q == GAP_LAST) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_TX_BUFFER_EN
        if (accept && state_q != IDLE) begin
            hold_d       = msgIn;
            hold_valid_d = 1'b1;
        end
        ready_d = !hold_valid_d;
`else
        ready_d = (state_d == IDLE);
`endif
        serial_d = (state_d == START) || (state_d == DATA && shift_d[MSG_WIDTH-1]);
        busy_d   = (state_d != IDLE);
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_BUFFER_EN
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_BUFFER_EN
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
`endif
        end
    end
endmodule
